key_event_arbiter: RTL and testbench

Front end for all push-button inputs of the game. For each raw key, the block:
- runs a 2-flop synchronizer chain,
- debounces the synchronized level,
- turns each debounced press into a sticky pending request.
A round-robin arbiter then serializes these requests into one valid/ready event stream for the game FSM (flap, start, pause, ...).

---
 rtl/key_event_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_key_event_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_arbiter.sv
// key_event_arbiter
//   Front end for the push-button inputs. Each raw key level goes through a
//   synchronizer chain, then a debouncer. Each debounced press becomes a
//   sticky pending request. A round-robin arbiter serializes the pending
//   requests into one valid/ready event stream.
//
//   Optional build macro: KEY_AUTOREPEAT_EN
//     When defined, a key that stays debounced-high raises a repeat press
//     every REPEAT_CYCLES cycles.
//     When undefined, each debounced press produces exactly one event.
//
// Ports
//   clock_i      system clock; all logic runs on posedge
//   reset_i      synchronous reset, active low
//   key_raw_i    asynchronous key levels, 1 = pressed
//   evt_valid_o  event offered to the consumer
//   evt_ready_i  consumer accepts the event
//   evt_key_o    index of the offered key; stable while evt_valid_o = 1
//   pending_o    per-key outstanding press flags
//   overflow_o   one-cycle pulse when a press is dropped because that key
//                already had a request pending
//
// Arbiter states
//   IDLE  | no event offered; pick the next pending key, scanning from rr_ptr
//   OFFER | evt_valid_o held high until the consumer accepts

module key_event_arbiter #(
  parameter int NUM_KEYS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 8
) (
  input  logic                        clock_i,
  input  logic                        reset_i,
  input  logic [NUM_KEYS-1:0]         key_raw_i,
  output logic                        evt_valid_o,
  input  logic                        evt_ready_i,
  output logic [$clog2(NUM_KEYS)-1:0] evt_key_o,
  output logic [NUM_KEYS-1:0]         pending_o,
  output logic                        overflow_o
);

  localparam int KW    = $clog2(NUM_KEYS);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [KW-1:0]    KEY_LAST = KW'(NUM_KEYS - 1);

  typedef enum logic {IDLE, OFFER} state_e;

  logic [NUM_KEYS-1:0][SYNC_STAGES-1:0] sync_q;
  logic [NUM_KEYS-1:0]                  sync_out;
  logic [NUM_KEYS-1:0]                  stable_q, stable_d, rise;
  logic [NUM_KEYS-1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_KEYS-1:0]                  press, hs, drop;
  logic [NUM_KEYS-1:0]                  pending_q, pending_d;
  logic                                 overflow_q;

  state_e          state_q;
  logic            evt_valid_q;
  logic [KW-1:0]   evt_key_q, rr_ptr_q, rr_next;
  logic            sel_found;
  logic [KW-1:0]   sel_idx;
  int              sel_scan;

  always_comb begin
    sync_out = '0;
    for (int k = 0; k < NUM_KEYS; k++) sync_out[k] = sync_q[k][SYNC_STAGES-1];
  end

  // The level is accepted in the same cycle the counter reaches its
  // terminal value, so rise is combinational and pending sets on that edge.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    rise     = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (sync_out[k] == stable_q[k]) begin
        cnt_d[k] = '0;
      end else if (cnt_q[k] == CNT_MAX) begin
        stable_d[k] = sync_out[k];
        cnt_d[k]    = '0;
        rise[k]     = sync_out[k];
      end else begin
        cnt_d[k] = cnt_q[k] + 1'b1;
      end
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_CYCLES - 1);

  logic [NUM_KEYS-1:0][REP_W-1:0] rep_q, rep_d;
  logic [NUM_KEYS-1:0]            rep_fire;

  // rep is already zero on the press edge, since it is held clear while
  // the debounced level is low.
  always_comb begin
    rep_d    = rep_q;
    rep_fire = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (!stable_q[k]) begin
        rep_d[k] = '0;
      end else if (rep_q[k] == REP_MAX) begin
        rep_d[k]    = '0;
        rep_fire[k] = 1'b1;
      end else begin
        rep_d[k] = rep_q[k] + 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) rep_q <= '0;
    else          rep_q <= rep_d;
  end

  assign press = rise | rep_fire;
`else
  assign press = rise;
`endif

  // A press that lands on the accepting handshake of the same key is kept
  // as a fresh request instead of being counted as an overflow.
  always_comb begin
    pending_d = pending_q;
    hs        = '0;
    drop      = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      hs[k] = evt_valid_q && evt_ready_i && (evt_key_q == KW'(k));
      if (press[k]) begin
        drop[k]      = pending_q[k] && !hs[k];
        pending_d[k] = 1'b1;
      end else if (hs[k]) begin
        pending_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      sync_q     <= '0;
      stable_q   <= '0;
      cnt_q      <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_KEYS; k++)
        sync_q[k] <= {sync_q[k][SYNC_STAGES-2:0], key_raw_i[k]};
      stable_q   <= stable_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      overflow_q <= |drop;
    end
  end

  // Scan from rr_ptr upward with wrap; NUM_KEYS need not be a power of 2.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_scan  = 0;
    for (int off = 0; off < NUM_KEYS; off++) begin
      sel_scan = int'(rr_ptr_q) + off;
      if (sel_scan >= NUM_KEYS) sel_scan = sel_scan - NUM_KEYS;
      if (!sel_found && pending_q[KW'(sel_scan)]) begin
        sel_found = 1'b1;
        sel_idx   = KW'(sel_scan);
      end
    end
  end

  assign rr_next = (evt_key_q == KEY_LAST) ? '0 : evt_key_q + 1'b1;

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q     <= IDLE;
      evt_valid_q <= 1'b0;
      evt_key_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sel_found) begin
            evt_key_q   <= sel_idx;
            evt_valid_q <= 1'b1;
            state_q     <= OFFER;
          end
        end
        OFFER: begin
          if (evt_ready_i) begin
            evt_valid_q <= 1'b0;
            rr_ptr_q    <= rr_next;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign evt_valid_o = evt_valid_q;
  assign evt_key_o   = evt_key_q;
  assign pending_o   = pending_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_key_event_arbiter.sv
// tb_key_event_arbiter
//   Self-checking bench for key_event_arbiter in its default build
//   (KEY_AUTOREPEAT_EN undefined). A behavioural model runs in step with
//   the DUT on every clock edge. Directed scenarios check fixed timing and
//   ordering. A randomized run compares every output against the model.

module tb_key_event_arbiter;

  localparam int NK = 4;
  localparam int SS = 2;
  localparam int DB = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          evt_ready = 1'b0;
  logic [NK-1:0] key_raw = '0;
  logic          evt_valid;
  logic [1:0]    evt_key;
  logic [NK-1:0] pending;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  key_event_arbiter #(
    .NUM_KEYS(NK), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB), .REPEAT_CYCLES(8)
  ) dut (
    .clock_i(clock), .reset_i(reset), .key_raw_i(key_raw),
    .evt_valid_o(evt_valid), .evt_ready_i(evt_ready), .evt_key_o(evt_key),
    .pending_o(pending), .overflow_o(overflow)
  );

  always #5 clock = ~clock;

  // Behavioural model: the synchronizer is a delay line, and the debouncer
  // counts how many consecutive edges the delayed level has disagreed with
  // the accepted level.
  logic [NK-1:0] rawq[$];
  logic [NK-1:0] m_stable = '0;
  int            m_run[NK];
  logic [NK-1:0] m_pend = '0;
  bit            m_valid = 0;
  int            m_key = 0;
  int            m_rr = 0;
  bit            m_ovf = 0;

  task automatic model_step();
    logic [NK-1:0] sout, rise, pend_old;
    int hs_key, best, bestd, d;
    bit ovf;
    if (!reset) begin
      rawq.delete();
      for (int i = 0; i < SS; i++) rawq.push_back('0);
      m_stable = '0;
      for (int k = 0; k < NK; k++) m_run[k] = 0;
      m_pend = '0; m_valid = 0; m_key = 0; m_rr = 0; m_ovf = 0;
      return;
    end
    sout = rawq.pop_front();
    rawq.push_back(key_raw);
    rise = '0;
    for (int k = 0; k < NK; k++) begin
      if (sout[k] != m_stable[k]) begin
        m_run[k]++;
        if (m_run[k] == DB) begin
          m_stable[k] = sout[k];
          m_run[k] = 0;
          rise[k] = sout[k];
        end
      end else begin
        m_run[k] = 0;
      end
    end
    pend_old = m_pend;
    hs_key = (m_valid && evt_ready) ? m_key : -1;
    ovf = 0;
    for (int k = 0; k < NK; k++) begin
      if (rise[k]) begin
        if (pend_old[k] && hs_key != k) ovf = 1;
        m_pend[k] = 1'b1;
      end else if (hs_key == k) begin
        m_pend[k] = 1'b0;
      end
    end
    if (!m_valid) begin
      if (pend_old != '0) begin
        best = 0; bestd = NK;
        for (int k = 0; k < NK; k++) begin
          d = (k - m_rr + NK) % NK;
          if (pend_old[k] && d < bestd) begin best = k; bestd = d; end
        end
        m_key = best;
        m_valid = 1;
      end
    end else if (evt_ready) begin
      m_valid = 0;
      m_rr = (m_key + 1) % NK;
    end
    m_ovf = ovf;
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; key_raw = '0; evt_ready = 1'b0;
    tick(); tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; key_raw = 4'hF; evt_ready = 1'b0;
    tick(); tick();
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", evt_valid); end
    checks++; if (pending !== 4'h0) begin errors++; $display("FAIL reset_pending got %h want 0", pending); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b want 0", overflow); end
    checks++; if (evt_key !== 2'd0) begin errors++; $display("FAIL reset_key got %0d want 0", evt_key); end
    reset = 1'b1;
    repeat (5) tick();
    checks++; if (pending !== 4'h0) begin errors++; $display("FAIL reset_pend_early got %h want 0", pending); end
    tick();
    checks++; if (pending !== 4'hF) begin errors++; $display("FAIL reset_pend_6 got %h want f", pending); end
  endtask

  task automatic test_single_press();
    do_reset();
    key_raw = 4'b0010; evt_ready = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL single_early edge %0d valid %0b want 0", e, evt_valid); end
    end
    tick();
    checks++; if (evt_valid !== 1'b1 || evt_key !== 2'd1) begin
      errors++; $display("FAIL single_edge7 valid %0b key %0d want 1/1", evt_valid, evt_key); end
    tick();
    checks++; if (evt_valid !== 1'b0 || pending[1] !== 1'b0) begin
      errors++; $display("FAIL single_after valid %0b pend1 %0b want 0/0", evt_valid, pending[1]); end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL single_held valid %0b want 0", evt_valid); end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    evt_ready = 1'b1;
    key_raw = 4'b0001;
    repeat (3) tick();
    key_raw = 4'b0000;
    for (int i = 0; i < 15; i++) begin
      tick();
      checks++; if (evt_valid !== 1'b0 || pending !== 4'h0) begin
        errors++; $display("FAIL glitch valid %0b pend %h want 0/0", evt_valid, pending); end
    end
  endtask

  task automatic test_round_robin();
    int grants[$];
    bit just_granted;
    bit seen;
    do_reset();
    key_raw = 4'b1011;
    repeat (6) tick();
    checks++; if (pending !== 4'b1011) begin errors++; $display("FAIL rr_pending got %b want 1011", pending); end
    evt_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      just_granted = 0;
      if (evt_valid) begin grants.push_back(int'(evt_key)); just_granted = 1; end
      tick();
      if (just_granted) begin
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL rr_gap valid %0b want 0", evt_valid); end
      end
    end
    checks++; if (grants.size() != 3) begin errors++; $display("FAIL rr_count got %0d want 3", grants.size()); end
    else begin
      checks++; if (grants[0] != 0 || grants[1] != 1 || grants[2] != 3) begin
        errors++; $display("FAIL rr_order got %0d,%0d,%0d want 0,1,3", grants[0], grants[1], grants[2]); end
    end
    key_raw = 4'b0000;
    repeat (10) tick();
    key_raw = 4'b0001;
    seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      tick();
      if (evt_valid) seen = 1;
    end
    checks++; if (!seen || evt_key !== 2'd0) begin
      errors++; $display("FAIL rr_repress seen %0b key %0d want 1/0", seen, evt_key); end
  endtask

  task automatic test_backpressure();
    int ovf_cnt, hs_cnt;
    do_reset();
    key_raw = 4'b0100;
    repeat (7) tick();
    checks++; if (evt_valid !== 1'b1 || evt_key !== 2'd2) begin
      errors++; $display("FAIL bp_offer valid %0b key %0d want 1/2", evt_valid, evt_key); end
    key_raw = 4'b0000;
    ovf_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 8) key_raw = 4'b0100;
      tick();
      if (overflow) ovf_cnt++;
      checks++; if (evt_valid !== 1'b1 || evt_key !== 2'd2) begin
        errors++; $display("FAIL bp_hold valid %0b key %0d want 1/2", evt_valid, evt_key); end
    end
    checks++; if (ovf_cnt != 1) begin errors++; $display("FAIL bp_overflow pulses %0d want 1", ovf_cnt); end
    evt_ready = 1'b1;
    hs_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (evt_valid && evt_ready) hs_cnt++;
      tick();
    end
    checks++; if (hs_cnt != 1) begin errors++; $display("FAIL bp_events got %0d want 1", hs_cnt); end
  endtask

  task automatic test_reset_mid_offer();
    bit seen;
    do_reset();
    evt_ready = 1'b1;
    key_raw = 4'b0010;
    seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin tick(); if (evt_valid) seen = 1; end
    tick();
    evt_ready = 1'b0;
    key_raw = 4'b1010;
    seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin tick(); if (evt_valid) seen = 1; end
    checks++; if (!seen || evt_key !== 2'd3) begin
      errors++; $display("FAIL mid_offer seen %0b key %0d want 1/3", seen, evt_key); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++; if (evt_valid !== 1'b0 || pending !== 4'h0) begin
      errors++; $display("FAIL mid_reset valid %0b pend %h want 0/0", evt_valid, pending); end
    seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin tick(); if (evt_valid) seen = 1; end
    checks++; if (!seen || evt_key !== 2'd1) begin
      errors++; $display("FAIL mid_rrptr seen %0b key %0d want 1/1", seen, evt_key); end
  endtask

  task automatic test_random();
    bit slow;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) slow = ($urandom_range(1) == 1);
      for (int k = 0; k < NK; k++)
        if ($urandom_range(7) == 0) key_raw[k] = ~key_raw[k];
      evt_ready = slow ? ($urandom_range(7) == 0) : ($urandom_range(1) == 1);
      reset = ($urandom_range(599) != 0);
      tick();
      checks++; if (evt_valid !== m_valid) begin
        errors++; $display("FAIL rand_valid cyc %0d got %0b want %0b", c, evt_valid, m_valid); end
      checks++; if (int'(evt_key) != m_key) begin
        errors++; $display("FAIL rand_key cyc %0d got %0d want %0d", c, evt_key, m_key); end
      checks++; if (pending !== m_pend) begin
        errors++; $display("FAIL rand_pending cyc %0d got %b want %b", c, pending, m_pend); end
      checks++; if (overflow !== m_ovf) begin
        errors++; $display("FAIL rand_overflow cyc %0d got %0b want %0b", c, overflow, m_ovf); end
    end
    reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < SS; i++) rawq.push_back('0);
    for (int k = 0; k < NK; k++) m_run[k] = 0;
    test_reset();
    test_single_press();
    test_glitch();
    test_round_robin();
    test_backpressure();
    test_reset_mid_offer();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
